// File: rtl/frame_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module  : frame_scan_ctrl
// Brief   : Two-pixel-per-cycle frame scan sequencer with front delay,
//           horizontal blanking, pipeline-aligned hsync and frame completion.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_scan_ctrl #(
  parameter int IMG_W     = 768,
  parameter int IMG_H     = 512,
  parameter int FRONT_DLY = 100,
  parameter int HBLANK    = 160,
  parameter int PIPE_LAT  = 2,
  parameter int ADDR_W    = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              pair_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [9:0]        row,
  output logic [8:0]        col,
  output logic              hsync_out,
  output logic              busy,
  output logic              frame_done,
  output logic              err_start
);

  localparam int c_CNT_MAX = (FRONT_DLY > HBLANK)
                           ? ((FRONT_DLY > PIPE_LAT) ? FRONT_DLY : PIPE_LAT)
                           : ((HBLANK > PIPE_LAT) ? HBLANK : PIPE_LAT);
  localparam int c_CNT_W = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_FRONT_LAST = c_CNT_W'(FRONT_DLY - 1);
  localparam logic [c_CNT_W-1:0] c_HB_LAST    = c_CNT_W'(HBLANK - 1);
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(PIPE_LAT - 1);
  localparam logic [8:0]         c_COL_LAST   = 9'(IMG_W / 2 - 1);
  localparam logic [9:0]         c_ROW_LAST   = 10'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FRONT  = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [PIPE_LAT-1:0] r_hs_sr;

  assign hsync_out = r_hs_sr[PIPE_LAT-1];

  // row/col/rd_addr always name the pair being presented (or next to present
  // once a stall or blanking gap ends); they step once the pair has gone out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hs_sr    <= '0;
      pair_valid <= 1'b0;
      rd_addr    <= '0;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_start  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_start  <= 1'b0;
      r_hs_sr    <= (r_hs_sr << 1) | PIPE_LAT'(pair_valid);
      if ((r_state != S_IDLE) && abort) begin
        r_state    <= S_IDLE;
        r_hs_sr    <= '0;
        pair_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        if ((r_state != S_IDLE) && start) begin
          err_start <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            if (start) begin
              row     <= '0;
              col     <= '0;
              rd_addr <= '0;
              r_cnt   <= '0;
              busy    <= 1'b1;
              if (FRONT_DLY == 0) begin
                r_state    <= S_ACTIVE;
                pair_valid <= 1'b1;
              end else begin
                r_state <= S_FRONT;
              end
            end
          end
          S_FRONT: begin
            if (r_cnt == c_FRONT_LAST) begin
              r_state    <= S_ACTIVE;
              pair_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
          S_ACTIVE: begin
            if (pair_valid) begin
              if (col == c_COL_LAST) begin
                if (row == c_ROW_LAST) begin
                  r_state    <= S_DRAIN;
                  pair_valid <= 1'b0;
                  r_cnt      <= '0;
                end else begin
                  row     <= row + 10'd1;
                  col     <= '0;
                  rd_addr <= rd_addr + ADDR_W'(2);
                  if (HBLANK == 0) begin
                    pair_valid <= !stall;
                  end else begin
                    r_state    <= S_HBLANK;
                    pair_valid <= 1'b0;
                    r_cnt      <= '0;
                  end
                end
              end else begin
                col        <= col + 9'd1;
                rd_addr    <= rd_addr + ADDR_W'(2);
                pair_valid <= !stall;
              end
            end else begin
              pair_valid <= !stall;
            end
          end
          S_HBLANK: begin
            if (r_cnt == c_HB_LAST) begin
              r_state    <= S_ACTIVE;
              pair_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
          S_DRAIN: begin
            // Hold busy until the final pair's hsync has left the delay line.
            if (r_cnt == c_DRAIN_LAST) begin
              r_state    <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            pair_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
